// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  localparam int          DIV_WIDTH_DEFAULT = 16;
  localparam int unsigned DIV_MIN           = 1;

  typedef logic [DIV_WIDTH_DEFAULT-1:0] div_t;

endpackage

// File: rtl/clk_div_counter.sv
// Loadable down-counter; flags the enabled cycle in which the count reaches 1.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int          DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 250
) (
  input  logic                 input_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 reload,
  input  logic [DIV_WIDTH-1:0] reload_value,
  output logic                 terminal
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(DIV_MIN);

  logic [DIV_WIDTH-1:0] count;

  assign terminal = enable && (count == ONE);

  // Reload has priority over counting; a disabled counter holds its value.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      count <= DIV_WIDTH'(DEFAULT_DIV);
    end else if (reload) begin
      count <= reload_value;
    end else if (enable) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable divide-by-2N clock generator with 50% duty output,
// registered rise/fall strobes and glitch-free divisor changes.
module programmable_clock_divider
  import clk_div_pkg::*;
#(
  parameter int          DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 250
) (
  input  logic                 input_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_clear,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 div_ack,
  output logic                 div_err,
  output logic                 output_clk,
  output logic                 rise_tick,
  output logic                 fall_tick
);

  logic [DIV_WIDTH-1:0] active_div;
  logic [DIV_WIDTH-1:0] pending_div;
  logic                 pending_valid;
  logic                 terminal_raw;
  logic                 boundary;
  logic                 reload;
  logic                 apply;
  logic [DIV_WIDTH-1:0] reload_value;

  // A clear overrides the half-period boundary; both restart the count.
  assign boundary     = terminal_raw && !sync_clear;
  assign reload       = boundary || sync_clear;
  assign apply        = reload && pending_valid;
  assign reload_value = pending_valid ? pending_div : active_div;

  clk_div_counter #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_counter (
    .input_clk    (input_clk),
    .reset        (reset),
    .enable       (enable),
    .reload       (reload),
    .reload_value (reload_value),
    .terminal     (terminal_raw)
  );

  // Divisor bookkeeping: a pending value is promoted at a reload; a load in the
  // same cycle refills the pending slot so it waits for the following boundary.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      active_div    <= DIV_WIDTH'(DEFAULT_DIV);
      pending_div   <= DIV_WIDTH'(DEFAULT_DIV);
      pending_valid <= 1'b0;
      div_ack       <= 1'b0;
      div_err       <= 1'b0;
    end else begin
      div_ack <= apply;
      div_err <= div_load && (div_value == '0);
      if (apply) begin
        active_div    <= pending_div;
        pending_valid <= 1'b0;
      end
      if (div_load && (div_value != '0)) begin
        pending_div   <= div_value;
        pending_valid <= 1'b1;
      end
    end
  end

  // Output clock toggles at each boundary; strobes mark the new level's first cycle.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      output_clk <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
    end else if (sync_clear) begin
      output_clk <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
    end else begin
      rise_tick <= boundary && !output_clk;
      fall_tick <= boundary &&  output_clk;
      if (boundary) begin
        output_clk <= !output_clk;
      end
    end
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider: vector table, directed
// multi-cycle sequences and randomized traffic against an elapsed-count model.
module tb_programmable_clock_divider;
  import clk_div_pkg::*;

  logic input_clk  = 1'b0;
  logic reset      = 1'b1;
  logic enable     = 1'b0;
  logic sync_clear = 1'b0;
  logic div_load   = 1'b0;
  div_t div_value  = '0;
  logic div_ack, div_err, output_clk, rise_tick, fall_tick;

  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;

  // Reference model state: half-period length, enabled cycles elapsed in the
  // current half-period, pending divisor (-1 when none) and expected outputs.
  int   m_n, m_el, m_pend;
  logic m_out, m_rise, m_fall, m_ack, m_err;

  typedef struct {
    logic en, clr, ld;
    int   val;
    logic out, rise, fall, ack, err;
  } vec_t;
  vec_t vecs[16];

  programmable_clock_divider #(
    .DIV_WIDTH   (16),
    .DEFAULT_DIV (250)
  ) dut (
    .input_clk  (input_clk),
    .reset      (reset),
    .enable     (enable),
    .sync_clear (sync_clear),
    .div_value  (div_value),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .output_clk (output_clk),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick)
  );

  always #5 input_clk = ~input_clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_n = 250; m_el = 0; m_pend = -1;
    m_out = 0; m_rise = 0; m_fall = 0; m_ack = 0; m_err = 0;
  endfunction

  function automatic void model_step(input logic en, input logic clr, input logic ld, input int val);
    m_ack = 0; m_rise = 0; m_fall = 0;
    m_err = ld && (val == 0);
    if (clr) begin
      m_out = 0; m_el = 0;
      if (m_pend > 0) begin m_n = m_pend; m_pend = -1; m_ack = 1; end
    end else if (en) begin
      m_el++;
      if (m_el == m_n) begin
        m_el = 0;
        m_out = !m_out;
        m_rise = m_out;
        m_fall = !m_out;
        if (m_pend > 0) begin m_n = m_pend; m_pend = -1; m_ack = 1; end
      end
    end
    if (ld && val != 0) m_pend = val;
  endfunction

  task automatic step(input logic en, input logic clr, input logic ld, input int val);
    enable = en; sync_clear = clr; div_load = ld; div_value = div_t'(val);
    @(posedge input_clk);
    model_step(en, clr, ld, val);
    #1;
    check("output_clk", output_clk, m_out);
    check("rise_tick",  rise_tick,  m_rise);
    check("fall_tick",  fall_tick,  m_fall);
    check("div_ack",    div_ack,    m_ack);
    check("div_err",    div_err,    m_err);
    if (div_ack === 1'b1) ack_cnt++;
    @(negedge input_clk);
    div_load = 1'b0; sync_clear = 1'b0;
  endtask

  task automatic run_until(input logic target, output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 0);
      n++;
    end while (output_clk !== target && n < 2000);
    if (output_clk !== target) begin
      checks++; errors++;
      $display("FAIL run_until_timeout actual=%0d expected=%0d", output_clk, target);
    end
  endtask

  task automatic half(output int n);
    run_until(!output_clk, n);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 0; sync_clear = 0; div_load = 0; div_value = '0;
    model_reset();
    repeat (2) @(negedge input_clk);
    reset = 1'b0;
  endtask

  function automatic void set_vec(input int i, input logic en, input logic clr, input logic ld, input int val,
                                  input logic out, input logic rise, input logic fall, input logic ack, input logic err);
    vecs[i].en = en; vecs[i].clr = clr; vecs[i].ld = ld; vecs[i].val = val;
    vecs[i].out = out; vecs[i].rise = rise; vecs[i].fall = fall; vecs[i].ack = ack; vecs[i].err = err;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, h3;
    logic held;

    //          en clr ld val  out rise fall ack err
    set_vec( 0, 0, 0, 1, 2,    0, 0, 0, 0, 0);
    set_vec( 1, 0, 1, 0, 0,    0, 0, 0, 1, 0);
    set_vec( 2, 1, 0, 0, 0,    0, 0, 0, 0, 0);
    set_vec( 3, 1, 0, 0, 0,    1, 1, 0, 0, 0);
    set_vec( 4, 1, 0, 0, 0,    1, 0, 0, 0, 0);
    set_vec( 5, 1, 0, 0, 0,    0, 0, 1, 0, 0);
    set_vec( 6, 1, 0, 1, 0,    0, 0, 0, 0, 1);
    set_vec( 7, 1, 0, 1, 1,    1, 1, 0, 0, 0);
    set_vec( 8, 0, 0, 0, 0,    1, 0, 0, 0, 0);
    set_vec( 9, 1, 0, 0, 0,    1, 0, 0, 0, 0);
    set_vec(10, 1, 0, 0, 0,    0, 0, 1, 1, 0);
    set_vec(11, 1, 0, 0, 0,    1, 1, 0, 0, 0);
    set_vec(12, 1, 0, 0, 0,    0, 0, 1, 0, 0);
    set_vec(13, 1, 0, 0, 0,    1, 1, 0, 0, 0);
    set_vec(14, 1, 1, 0, 0,    0, 0, 0, 0, 0);
    set_vec(15, 1, 0, 0, 0,    1, 1, 0, 0, 0);

    // Reset values
    model_reset();
    #1;
    check("rst_output_clk", output_clk, 1'b0);
    check("rst_rise_tick",  rise_tick,  1'b0);
    check("rst_fall_tick",  fall_tick,  1'b0);
    check("rst_div_ack",    div_ack,    1'b0);
    check("rst_div_err",    div_err,    1'b0);
    do_reset();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].val);
      check($sformatf("vec%0d_out",  i), output_clk, vecs[i].out);
      check($sformatf("vec%0d_rise", i), rise_tick,  vecs[i].rise);
      check($sformatf("vec%0d_fall", i), fall_tick,  vecs[i].fall);
      check($sformatf("vec%0d_ack",  i), div_ack,    vecs[i].ack);
      check($sformatf("vec%0d_err",  i), div_err,    vecs[i].err);
    end

    // Default divisor: first rise after 250 cycles, 500-cycle period
    do_reset();
    run_until(1'b1, h);
    check("first_rise_cycles", h, 250);
    half(h1);
    half(h2);
    check("default_period", h1 + h2, 500);

    // Load 3 mid half-period
    repeat (100) step(1, 0, 0, 0);
    ack_cnt = 0;
    step(1, 0, 1, 3);
    half(h);
    check("load3_old_half", 101 + h, 250);
    half(h2);
    half(h3);
    check("load3_half_a", h2, 3);
    check("load3_half_b", h3, 3);
    check("load3_ack_count", ack_cnt, 1);

    // Load on the terminal cycle: old N used once more
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 6);
    half(h);
    check("term_load_old_half", h, 3);
    half(h);
    check("term_load_new_half", h, 6);

    // Back-to-back loads: last wins, single ack
    ack_cnt = 0;
    step(1, 0, 1, 5);
    step(1, 0, 1, 7);
    half(h);
    check("b2b_old_half", 2 + h, 6);
    half(h);
    check("b2b_new_half", h, 7);
    check("b2b_ack_count", ack_cnt, 1);

    // Zero divisor rejected
    step(1, 0, 1, 0);
    check("zero_div_err", div_err, 1'b1);
    half(h);
    check("zero_half_a", 1 + h, 7);
    half(h);
    check("zero_half_b", h, 7);

    // N = 1
    step(1, 0, 1, 1);
    half(h);
    check("n1_old_half", 1 + h, 7);
    for (int k = 0; k < 3; k++) begin
      half(h);
      check($sformatf("n1_half%0d", k), h, 1);
    end

    // Enable low for 40 cycles mid half-period
    step(1, 0, 1, 10);
    half(h);
    check("n10_apply_half", h, 1);
    half(h);
    check("n10_half", h, 10);
    repeat (4) step(1, 0, 0, 0);
    held = output_clk;
    repeat (40) step(0, 0, 0, 0);
    check("hold_output_clk", output_clk, held);
    half(h);
    check("hold_total_half", 44 + h, 50);

    // sync_clear while output_clk is high
    if (output_clk !== 1'b1) half(h);
    step(1, 1, 0, 0);
    check("clear_output_clk", output_clk, 1'b0);
    run_until(1'b1, h);
    check("clear_next_rise", h, 10);

    // Asynchronous reset mid-period discards the pending divisor
    step(1, 0, 1, 20);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_output_clk", output_clk, 1'b0);
    check("async_rst_div_ack", div_ack, 1'b0);
    model_reset();
    @(negedge input_clk);
    reset = 1'b0;
    run_until(1'b1, h);
    check("post_rst_first_rise", h, 250);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 16) == 0, int'($urandom % 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
